// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative radix-2 multiply/divide unit with HI/LO registers.
//
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract) one
// bit per cycle. It also provides the architectural HI/LO registers that are
// used by MTHI/MTLO/MFHI/MFLO.
//
// Optional build macro: MD_EARLY_TERM_EN
//   When defined, a multiply leaves CALC once no set multiplier bits remain.
//   When undefined, every operation takes WIDTH CALC cycles.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   start a new operation (sampled only when idle)
//   op     in   11 MULT, 01 MULTU, 10 DIV, 00 DIVU
//   a      in   rs operand (multiplicand / dividend)
//   b      in   rt operand (multiplier / divisor)
//   hi_we  in   MTHI write strobe (idle only)
//   lo_we  in   MTLO write strobe (idle only)
//   wdata  in   MTHI/MTLO write data
//   busy   out  operation in progress
//   done   out  one-cycle pulse when the new HI/LO is visible
//   dz     out  divide-by-zero flag of the last completed operation
//   hi     out  HI register
//   lo     out  LO register
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNTW-1:0]    cnt_q;
    logic               mul_q;      // 1: multiply, 0: divide
    logic               qneg_q;     // negate product / quotient
    logic               rneg_q;     // negate remainder (sign of dividend)
    // Multiply: product accumulator. Divide: {remainder(W+1), quotient(W)}.
    logic [2*WIDTH:0]   acc_q;
    // Multiply: multiplicand shifting left. Divide: divisor in the low half.
    logic [2*WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0]   mpl_q;      // multiplier, consumed LSB first
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dz_q;

    // Operand magnitudes. Only MULT and DIV (op[1]=1) are signed.
    logic             a_neg_d, b_neg_d;
    logic [WIDTH-1:0] a_mag_d, b_mag_d;

    assign a_neg_d = op[1] & a[WIDTH-1];
    assign b_neg_d = op[1] & b[WIDTH-1];
    assign a_mag_d = a_neg_d ? -a : a;
    assign b_mag_d = b_neg_d ? -b : b;

    // One multiply step: add the shifted multiplicand when the multiplier bit is set.
    logic [2*WIDTH:0] acc_mul_d;
    assign acc_mul_d = mpl_q[0] ? (acc_q + {1'b0, opnd_q}) : acc_q;

    // One restoring divide step. The partial remainder is shifted left and
    // the next dividend bit is brought in. The trial subtraction is one bit
    // wider so that its MSB works as the borrow.
    logic [2*WIDTH:0] div_sh_d;
    logic [WIDTH+1:0] div_trial_d;
    logic [2*WIDTH:0] acc_div_d;

    assign div_sh_d    = {acc_q[2*WIDTH-1:0], 1'b0};
    assign div_trial_d = {1'b0, div_sh_d[2*WIDTH:WIDTH]} - {2'b00, opnd_q[WIDTH-1:0]};
    assign acc_div_d   = div_trial_d[WIDTH+1]
                       ? div_sh_d
                       : {div_trial_d[WIDTH:0], div_sh_d[WIDTH-1:1], 1'b1};

    // Exit condition for CALC.
    logic early_exit_d;
`ifdef MD_EARLY_TERM_EN
    // After this cycle, the only unconsumed multiplier bits are mpl_q[WIDTH-1:1].
    assign early_exit_d = mul_q & (mpl_q[WIDTH-1:1] == '0);
`else
    assign early_exit_d = 1'b0;
`endif

    logic calc_last_d;
    assign calc_last_d = (cnt_q == CNTW'(1)) | early_exit_d;

    // Sign fix-up and HI/LO selection for the FIX cycle.
    logic [2*WIDTH-1:0] prod_fix_d;
    logic [WIDTH-1:0]   quo_fix_d, rem_fix_d;
    logic               div_zero_d;
    logic [WIDTH-1:0]   hi_fix_d, lo_fix_d;

    assign prod_fix_d = qneg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    assign quo_fix_d  = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    // The remainder is smaller than the divisor, so it fits in WIDTH bits.
    // With a zero divisor, the remainder ends up as |a|. Applying the
    // dividend's sign to it gives back the original a.
    assign rem_fix_d  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign div_zero_d = (opnd_q[WIDTH-1:0] == '0);
    assign hi_fix_d   = mul_q ? prod_fix_d[2*WIDTH-1:WIDTH] : rem_fix_d;
    assign lo_fix_d   = mul_q ? prod_fix_d[WIDTH-1:0]
                              : (div_zero_d ? '1 : quo_fix_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            mpl_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // A start request takes priority over MTHI/MTLO writes in the same cycle.
                        mul_q   <= op[0];
                        qneg_q  <= a_neg_d ^ b_neg_d;
                        rneg_q  <= a_neg_d;
                        acc_q   <= op[0] ? '0 : {{(WIDTH+1){1'b0}}, a_mag_d};
                        opnd_q  <= {{WIDTH{1'b0}}, (op[0] ? a_mag_d : b_mag_d)};
                        mpl_q   <= b_mag_d;
                        cnt_q   <= CNTW'(WIDTH);
                        state_q <= S_CALC;
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q - CNTW'(1);
                    if (mul_q) begin
                        acc_q  <= acc_mul_d;
                        opnd_q <= opnd_q << 1;
                        mpl_q  <= mpl_q >> 1;
                    end else begin
                        acc_q  <= acc_div_d;
                    end
                    if (calc_last_d) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= hi_fix_d;
                    lo_q    <= lo_fix_d;
                    dz_q    <= ~mul_q & div_zero_d;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit -- self-checking bench for mul_div_unit (WIDTH=32).
// Directed cases and randomized operations are compared against a
// plain-arithmetic reference model. Honours MD_EARLY_TERM_EN for latency.
module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] last_hi, last_lo;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: result, dz and start-to-done latency from plain arithmetic.
    function automatic void ref_md(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl,
                                   output logic rdz, output int lat);
        logic [63:0] xe, ye, p;
        longint sx, sy, q, r;
`ifdef MD_EARLY_TERM_EN
        logic [W-1:0] ym;
`endif
        lat = W + 2;
        rdz = 1'b0;
        if (o[0]) begin
            xe = o[1] ? {{32{x[31]}}, x} : {32'b0, x};
            ye = o[1] ? {{32{y[31]}}, y} : {32'b0, y};
            p  = xe * ye;
            rh = p[63:32];
            rl = p[31:0];
`ifdef MD_EARLY_TERM_EN
            ym  = (o[1] && y[31]) ? -y : y;
            lat = 3;
            for (int i = 0; i < W; i++) if (ym[i]) lat = i + 3;
`endif
        end else if (y == '0) begin
            rh  = x;
            rl  = '1;
            rdz = 1'b1;
        end else if (o[1]) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q  = sx / sy;
            r  = sx % sy;
            rl = q[31:0];
            rh = r[31:0];
        end else begin
            rl = x / y;
            rh = x % y;
        end
    endfunction

    // mode 0: plain; 1: re-pulse start + hi_we at cycle 10; 2: hi_we/lo_we with start.
    task automatic run_op(input logic [1:0] op_v, input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input int mode);
        logic [W-1:0] eh, el, hi0;
        logic         edz;
        int           lat, done_cyc;
        bit           busy_ok;
        ref_md(op_v, a_v, b_v, eh, el, edz, lat);
        hi0   = hi;
        op    = op_v;
        a     = a_v;
        b     = b_v;
        start = 1'b1;
        if (mode == 2) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'h5A5A_0F0F;
        end
        step();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (mode == 2) check("start_beats_wr", hi, hi0);
        done_cyc = -1;
        busy_ok  = 1'b1;
        for (int c = 1; c <= W + 6; c++) begin
            if (done) begin
                done_cyc = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (mode == 1 && c == 10) begin
                start = 1'b1;
                hi_we = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
            step();
            start = 1'b0;
            hi_we = 1'b0;
            if (mode == 1 && c == 10) check("busy_wr_ignored", hi, hi0);
        end
        check("latency", done_cyc, lat);
        check("busy_during", busy_ok, 1);
        check("busy_at_done", busy, 0);
        check("hi", hi, eh);
        check("lo", lo, el);
        check("dz", dz, edz);
        last_hi = eh;
        last_lo = el;
        step();
        check("done_pulse", done, 0);
    endtask

    initial begin
        int n_done;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", dz, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b0;

        // MTHI / MTLO in idle
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        step();
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'hA5A5_A5A5);
        check("mthi_lo", lo, 0);
        lo_we = 1'b1; wdata = 32'h1234_5678;
        step();
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h1234_5678);
        check("mtlo_hi", hi, 32'hA5A5_A5A5);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1111_1111;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        check("both_hi", hi, 32'h1111_1111);
        check("both_lo", lo, 32'h1111_1111);

        // Directed operations
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        run_op(2'b11, 32'hFFFF_FFFD, 32'd5, 0);
        check("mult_neg_lo", lo, 32'hFFFF_FFF1);
        run_op(2'b10, -32'sd7, 32'd2, 0);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_minneg1_lo", lo, 32'h8000_0000);
        run_op(2'b00, 32'h0000_1234, 32'd0, 0);
        check("divu_z_hi", hi, 32'h0000_1234);
        check("divu_z_dz", dz, 1);
        run_op(2'b00, 32'd10, 32'd3, 0);
        check("divu_10_3_dz", dz, 0);
        run_op(2'b10, 32'h8000_0000, 32'd0, 0);
        run_op(2'b11, 32'h1234_5678, 32'd0, 0);
        run_op(2'b11, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'b01, 32'hCAFE_F00D, 32'h1234_5678, 1);
        run_op(2'b00, 32'hFFFF_FFF0, 32'd7, 2);

        // HI/LO hold while idle
        repeat (5) step();
        check("hold_hi", hi, last_hi);
        check("hold_lo", lo, last_lo);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            logic [1:0]   o;
            logic [W-1:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0:       y = '0;
                1, 2:    y = W'($urandom_range(0, 255));
                3:       x = 32'h8000_0000;
                4:       y = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(o, x, y, 0);
        end

        // Reset in the middle of a DIV, with nonzero HI/LO and dz set
        run_op(2'b00, 32'h0000_4321, 32'd0, 0);
        op = 2'b10; a = -32'sd100; b = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        reset = 1'b1;
        step();
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_busy", busy, 0);
        check("midrst_dz", dz, 0);
        reset = 1'b0;
        n_done = 0;
        repeat (40) begin
            step();
            if (done) n_done++;
        end
        check("midrst_no_done", n_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
